// File: rtl/pwm_duty_seq_v1.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_duty_seq_v1
//  Brief    : Steps through a duty table, writing one CFG0 word to the PWM
//             SFR block per accepted PWM period-match event via a bus master.
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_duty_seq_v1 #(
    parameter int          DATA_WIDTH    = 32,
    parameter int          ADDR_WIDTH    = 32,
    parameter int unsigned PWM_BASE_ADDR = 0,
    parameter int          DEPTH         = 8,
    parameter int          N             = 16,
    localparam int         IW            = $clog2(DEPTH)
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  sys_clk_en,
    input  logic                  tbl_wr_en,
    input  logic [IW-1:0]         tbl_wr_idx,
    input  logic [N-1:0]          tbl_wr_data,
    input  logic [N-1:0]          seq_period,
    input  logic [IW-1:0]         seq_len,
    input  logic                  seq_loop,
    input  logic                  seq_start,
    input  logic                  seq_stop,
    input  logic                  pr_event,
    input  logic                  bus_gnt,
    output logic                  bus_req,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic                  m_wr_en,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic                  seq_busy,
    output logic [IW-1:0]         seq_idx,
    output logic                  seq_done,
    output logic                  seq_ovr
);

    localparam logic [ADDR_WIDTH-1:0] CFG0_ADDR = ADDR_WIDTH'(PWM_BASE_ADDR + 32'd8);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_PR = 2'd1,
        ST_REQ     = 2'd2,
        ST_WRITE   = 2'd3
    } state_t;

    state_t                  state_q,   state_d;
    logic                    bus_req_q, bus_req_d;
    logic                    wr_en_q,   wr_en_d;
    logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,   wdata_d;
    logic                    busy_q;
    logic [IW-1:0]           idx_q,     idx_d;
    logic                    done_q,    done_d;
    logic                    ovr_q,     ovr_d;
    logic [N-1:0]            tbl_q [DEPTH];

    logic [N-1:0]            w_duty;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic                    w_last;

    assign w_duty = tbl_q[idx_q];
    // An index at or beyond a (possibly shrunk) seq_len is treated as the last entry.
    assign w_last = (idx_q >= seq_len);

    // CFG0 layout: period in bits [31:16], duty in bits [15:0], zero-padded.
    for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_wdata
        if (g < 16 && g < N) begin : g_duty
            assign w_wdata[g] = w_duty[g];
        end else if (g >= 16 && g < 32 && (g - 16) < N) begin : g_period
            assign w_wdata[g] = seq_period[g-16];
        end else begin : g_zero
            assign w_wdata[g] = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        bus_req_d = bus_req_q;
        wr_en_d   = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        ovr_d     = ovr_q;

        // Period events arriving while a write is outstanding are dropped, not queued.
        if ((state_q == ST_REQ || state_q == ST_WRITE) && pr_event) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (seq_start) begin
                    state_d = ST_WAIT_PR;
                    idx_d   = '0;
                    ovr_d   = 1'b0;
                end
            end
            ST_WAIT_PR: begin
                if (seq_stop) begin
                    state_d = ST_IDLE;
                end else if (pr_event) begin
                    state_d   = ST_REQ;
                    bus_req_d = 1'b1;
                end
            end
            ST_REQ: begin
                if (seq_stop) begin
                    state_d   = ST_IDLE;
                    bus_req_d = 1'b0;
                end else if (bus_gnt) begin
                    state_d = ST_WRITE;
                    wr_en_d = 1'b1;
                    addr_d  = CFG0_ADDR;
                    wdata_d = w_wdata;
                end
            end
            ST_WRITE: begin
                bus_req_d = 1'b0;
                if (seq_stop) begin
                    state_d = ST_IDLE;
                end else if (!w_last) begin
                    state_d = ST_WAIT_PR;
                    idx_d   = idx_q + IW'(1);
                end else if (seq_loop) begin
                    state_d = ST_WAIT_PR;
                    idx_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            bus_req_q <= 1'b0;
            wr_en_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            idx_q     <= '0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= '0;
            end
        end else if (sys_clk_en) begin
            state_q   <= state_d;
            bus_req_q <= bus_req_d;
            wr_en_q   <= wr_en_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            busy_q    <= (state_d != ST_IDLE);
            idx_q     <= idx_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
            if (tbl_wr_en) begin
                tbl_q[tbl_wr_idx] <= tbl_wr_data;
            end
        end
    end

    // Strobes are masked rather than cleared so a stalled WRITE still issues its pulse on resume.
    assign m_wr_en  = wr_en_q & sys_clk_en;
    assign seq_done = done_q & sys_clk_en;
    assign bus_req  = bus_req_q;
    assign m_addr   = addr_q;
    assign m_wdata  = wdata_q;
    assign seq_busy = busy_q;
    assign seq_idx  = idx_q;
    assign seq_ovr  = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_seq_v1.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_duty_seq_v1
//  Brief    : Directed self-checking bench for pwm_duty_seq_v1.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_duty_seq_v1;

    localparam int          DW   = 32;
    localparam int          AW   = 32;
    localparam int unsigned BASE = 32'h100;
    localparam int          IW   = 3;
    localparam int          NW   = 16;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          sys_clk_en = 1'b1;
    logic          tbl_wr_en = 1'b0;
    logic [IW-1:0] tbl_wr_idx = '0;
    logic [NW-1:0] tbl_wr_data = '0;
    logic [NW-1:0] seq_period = '0;
    logic [IW-1:0] seq_len = '0;
    logic          seq_loop = 1'b0;
    logic          seq_start = 1'b0;
    logic          seq_stop = 1'b0;
    logic          pr_event = 1'b0;
    logic          bus_gnt = 1'b0;
    logic          bus_req;
    logic [AW-1:0] m_addr;
    logic          m_wr_en;
    logic [DW-1:0] m_wdata;
    logic          seq_busy;
    logic [IW-1:0] seq_idx;
    logic          seq_done;
    logic          seq_ovr;

    int checks = 0;
    int failures = 0;

    pwm_duty_seq_v1 #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .PWM_BASE_ADDR(BASE),
        .DEPTH        (8),
        .N            (NW)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .sys_clk_en (sys_clk_en),
        .tbl_wr_en  (tbl_wr_en),
        .tbl_wr_idx (tbl_wr_idx),
        .tbl_wr_data(tbl_wr_data),
        .seq_period (seq_period),
        .seq_len    (seq_len),
        .seq_loop   (seq_loop),
        .seq_start  (seq_start),
        .seq_stop   (seq_stop),
        .pr_event   (pr_event),
        .bus_gnt    (bus_gnt),
        .bus_req    (bus_req),
        .m_addr     (m_addr),
        .m_wr_en    (m_wr_en),
        .m_wdata    (m_wdata),
        .seq_busy   (seq_busy),
        .seq_idx    (seq_idx),
        .seq_done   (seq_done),
        .seq_ovr    (seq_ovr)
    );

    always #5 sys_clk = ~sys_clk;

    // Advance across one rising edge; outputs are then sampled on the falling edge.
    task automatic tick();
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_entry(input int idx, input logic [NW-1:0] val);
        tbl_wr_en   = 1'b1;
        tbl_wr_idx  = IW'(idx);
        tbl_wr_data = val;
        tick();
        tbl_wr_en   = 1'b0;
    endtask

    // One accepted period event with bus_gnt already high: REQ, WRITE, then release.
    task automatic event_and_write(input string tag, input logic [31:0] exp_wdata);
        pr_event = 1'b1;
        tick();
        pr_event = 1'b0;
        chk({tag, "_req"}, 64'(bus_req), 64'd1);
        tick();
        chk({tag, "_wr_en"}, 64'(m_wr_en), 64'd1);
        chk({tag, "_addr"}, 64'(m_addr), 64'(BASE + 8));
        chk({tag, "_wdata"}, 64'(m_wdata), 64'(exp_wdata));
        tick();
        chk({tag, "_wr_end"}, 64'(m_wr_en), 64'd0);
        chk({tag, "_req_end"}, 64'(bus_req), 64'd0);
    endtask

    initial begin
        // Reset
        @(negedge sys_clk);
        tick();
        tick();
        sys_rst = 1'b0;
        chk("rst_bus_req", 64'(bus_req), 64'd0);
        chk("rst_wr_en", 64'(m_wr_en), 64'd0);
        chk("rst_addr", 64'(m_addr), 64'd0);
        chk("rst_wdata", 64'(m_wdata), 64'd0);
        chk("rst_busy", 64'(seq_busy), 64'd0);
        chk("rst_idx", 64'(seq_idx), 64'd0);
        chk("rst_done", 64'(seq_done), 64'd0);
        chk("rst_ovr", 64'(seq_ovr), 64'd0);

        // Single-shot sequence of three entries
        load_entry(0, 16'h0100);
        load_entry(1, 16'h0200);
        load_entry(2, 16'h0300);
        seq_len    = 3'd2;
        seq_loop   = 1'b0;
        seq_period = 16'h0400;
        bus_gnt    = 1'b1;
        seq_start  = 1'b1;
        tick();
        seq_start  = 1'b0;
        chk("s1_busy", 64'(seq_busy), 64'd1);
        chk("s1_idx0", 64'(seq_idx), 64'd0);
        chk("s1_idle_req", 64'(bus_req), 64'd0);
        event_and_write("s1_w0", 32'h0400_0100);
        chk("s1_idx1", 64'(seq_idx), 64'd1);
        chk("s1_nodone0", 64'(seq_done), 64'd0);
        event_and_write("s1_w1", 32'h0400_0200);
        chk("s1_idx2", 64'(seq_idx), 64'd2);
        event_and_write("s1_w2", 32'h0400_0300);
        chk("s1_done", 64'(seq_done), 64'd1);
        chk("s1_busy_end", 64'(seq_busy), 64'd0);
        tick();
        chk("s1_done_pulse", 64'(seq_done), 64'd0);

        // Looping sequence: entries 0,1,2,0,1
        seq_loop  = 1'b1;
        seq_start = 1'b1;
        tick();
        seq_start = 1'b0;
        event_and_write("s2_w0", 32'h0400_0100);
        event_and_write("s2_w1", 32'h0400_0200);
        event_and_write("s2_w2", 32'h0400_0300);
        chk("s2_wrap_idx", 64'(seq_idx), 64'd0);
        chk("s2_nodone", 64'(seq_done), 64'd0);
        event_and_write("s2_w3", 32'h0400_0100);
        event_and_write("s2_w4", 32'h0400_0200);
        chk("s2_idx_end", 64'(seq_idx), 64'd2);
        chk("s2_busy", 64'(seq_busy), 64'd1);
        chk("s2_nodone_end", 64'(seq_done), 64'd0);
        seq_stop = 1'b1;
        tick();
        seq_stop = 1'b0;
        chk("s2_stop_busy", 64'(seq_busy), 64'd0);

        // Held-off grant, overrun on a second event
        seq_loop  = 1'b0;
        bus_gnt   = 1'b0;
        seq_start = 1'b1;
        tick();
        seq_start = 1'b0;
        pr_event  = 1'b1;
        tick();
        pr_event  = 1'b0;
        chk("s3_ovr_clear", 64'(seq_ovr), 64'd0);
        for (int i = 0; i < 10; i++) begin
            pr_event = (i == 3);
            tick();
            chk("s3_req_hold", 64'(bus_req), 64'd1);
            chk("s3_no_wr", 64'(m_wr_en), 64'd0);
        end
        pr_event = 1'b0;
        chk("s3_ovr_set", 64'(seq_ovr), 64'd1);
        bus_gnt = 1'b1;
        tick();
        chk("s3_wr", 64'(m_wr_en), 64'd1);
        chk("s3_wdata", 64'(m_wdata), 64'h0400_0100);
        tick();
        chk("s3_single_wr", 64'(m_wr_en), 64'd0);
        chk("s3_idx", 64'(seq_idx), 64'd1);
        chk("s3_ovr_sticky", 64'(seq_ovr), 64'd1);

        // Stop while requesting: no write even though grant follows
        bus_gnt  = 1'b0;
        pr_event = 1'b1;
        tick();
        pr_event = 1'b0;
        chk("s4_req", 64'(bus_req), 64'd1);
        seq_stop = 1'b1;
        bus_gnt  = 1'b1;
        tick();
        seq_stop = 1'b0;
        chk("s4_stop_req", 64'(bus_req), 64'd0);
        chk("s4_stop_wr", 64'(m_wr_en), 64'd0);
        chk("s4_stop_busy", 64'(seq_busy), 64'd0);
        tick();
        chk("s4_stop_wr2", 64'(m_wr_en), 64'd0);

        // Stop during WRITE: write completes, no done; start and stop together in IDLE
        seq_start = 1'b1;
        seq_stop  = 1'b1;
        tick();
        seq_start = 1'b0;
        seq_stop  = 1'b0;
        chk("s4_start_wins", 64'(seq_busy), 64'd1);
        chk("s4_ovr_cleared", 64'(seq_ovr), 64'd0);
        seq_len  = 3'd0;
        pr_event = 1'b1;
        tick();
        pr_event = 1'b0;
        tick();
        chk("s4_wr_in_stop", 64'(m_wr_en), 64'd1);
        seq_stop = 1'b1;
        tick();
        seq_stop = 1'b0;
        chk("s4_wstop_busy", 64'(seq_busy), 64'd0);
        chk("s4_wstop_done", 64'(seq_done), 64'd0);
        chk("s4_wstop_wr", 64'(m_wr_en), 64'd0);

        // Reset during REQ with grant in the same cycle
        seq_len   = 3'd2;
        bus_gnt   = 1'b0;
        seq_start = 1'b1;
        tick();
        seq_start = 1'b0;
        pr_event  = 1'b1;
        tick();
        pr_event  = 1'b0;
        sys_rst   = 1'b1;
        bus_gnt   = 1'b1;
        tick();
        sys_rst   = 1'b0;
        chk("s5_wr", 64'(m_wr_en), 64'd0);
        chk("s5_req", 64'(bus_req), 64'd0);
        chk("s5_addr", 64'(m_addr), 64'd0);
        chk("s5_wdata", 64'(m_wdata), 64'd0);
        chk("s5_busy", 64'(seq_busy), 64'd0);
        chk("s5_idx", 64'(seq_idx), 64'd0);

        // Table was cleared by reset; also seq_len=0 single entry ends at once
        seq_len   = 3'd0;
        seq_start = 1'b1;
        tick();
        seq_start = 1'b0;
        event_and_write("s5_tbl0", 32'h0400_0000);
        chk("s5_len0_done", 64'(seq_done), 64'd1);

        // Clock enable low in WAIT_PR: events and table writes ignored
        load_entry(0, 16'h0100);
        load_entry(1, 16'h0200);
        load_entry(2, 16'h0300);
        seq_len   = 3'd2;
        seq_start = 1'b1;
        tick();
        seq_start   = 1'b0;
        sys_clk_en  = 1'b0;
        tbl_wr_en   = 1'b1;
        tbl_wr_idx  = 3'd0;
        tbl_wr_data = 16'hAAAA;
        for (int i = 0; i < 4; i++) begin
            pr_event = (i % 2 == 0);
            tick();
            chk("s6_hold_req", 64'(bus_req), 64'd0);
            chk("s6_hold_busy", 64'(seq_busy), 64'd1);
        end
        pr_event   = 1'b0;
        tbl_wr_en  = 1'b0;
        sys_clk_en = 1'b1;
        tick();
        chk("s6_resume_idle", 64'(bus_req), 64'd0);
        event_and_write("s6_w0", 32'h0400_0100);

        // Shrinking seq_len below the current index ends the sequence at next write
        seq_len = 3'd0;
        event_and_write("s7_w1", 32'h0400_0200);
        chk("s7_done", 64'(seq_done), 64'd1);
        chk("s7_busy", 64'(seq_busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
